// File: rtl/jtag_debug_sysclk_cmd_queue_pkg.sv
// Shared constants for the system-clock side of the JTAG debug command queue.
package jtag_debug_sysclk_cmd_queue_pkg;
  localparam int IR_W_DEF    = 2;
  localparam int DR_W_DEF    = 38;
  localparam int ACT_BIT_DEF = 35;
  localparam int ENTRY_W     = IR_W_DEF + DR_W_DEF;

  typedef enum logic [1:0] {
    JTAG_IR_OCIMEM    = 2'd0,
    JTAG_IR_TRACEMEM  = 2'd1,
    JTAG_IR_BREAK     = 2'd2,
    JTAG_IR_TRACECTRL = 2'd3
  } jtag_ir_e;
endpackage

// File: rtl/jtag_debug_sysclk_cmd_queue_if.sv
// Bundle between the TCK-domain shifter, the command queue and the OCI consumers.
interface jtag_debug_sysclk_cmd_queue_if
  import jtag_debug_sysclk_cmd_queue_pkg::*;
#(
  parameter int IR_W  = IR_W_DEF,
  parameter int DR_W  = DR_W_DEF,
  parameter int DEPTH = 4
);
  localparam int NCH   = 2**IR_W;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [IR_W-1:0]  ir_in;
  logic [DR_W-1:0]  sr;
  logic             vs_udr;
  logic             vs_uir;
  logic             cmd_ready;
  logic             ovf_clr;
  logic [DR_W-1:0]  jdo;
  logic [NCH-1:0]   take_action;
  logic [NCH-1:0]   take_no_action;
  logic             ir_update;
  logic [IR_W-1:0]  ir_latched;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;

  modport master (
    output ir_in, sr, vs_udr, vs_uir, cmd_ready, ovf_clr,
    input  jdo, take_action, take_no_action, ir_update, ir_latched, fifo_level, overflow
  );

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir, cmd_ready, ovf_clr,
    output jdo, take_action, take_no_action, ir_update, ir_latched, fifo_level, overflow
  );
endinterface

// File: rtl/jtag_debug_sysclk_cmd_queue_sync_edge.sv
// Multi-flop synchroniser with registered rising-edge pulse.
// Flops reset high so a strobe already asserted at reset release gives no edge.
module jtag_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_p
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
      r_hist <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist;
    end
  end

  assign rise_p = r_rise;
endmodule

// File: rtl/jtag_debug_sysclk_cmd_queue.sv
// System-clock side of the JTAG debug module: queues scanned commands and
// dispatches them one at a time as one-hot action / no-action pulses.
module jtag_debug_sysclk_cmd_queue
  import jtag_debug_sysclk_cmd_queue_pkg::*;
#(
  parameter int IR_W        = IR_W_DEF,
  parameter int DR_W        = DR_W_DEF,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  jtag_debug_sysclk_cmd_queue_if.slave  bus
);
  localparam int NCH   = 2**IR_W;
  localparam int EW    = IR_W + DR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic w_udr_p, w_uir_p;

  jtag_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk(clk), .reset(reset), .async_in(bus.vs_udr), .rise_p(w_udr_p)
  );

  jtag_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk(clk), .reset(reset), .async_in(bus.vs_uir), .rise_p(w_uir_p)
  );

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;
  logic [DR_W-1:0]  r_jdo;
  logic [NCH-1:0]   r_take_act, r_take_nact;
  logic [IR_W-1:0]  r_ir_latched;

  logic [EW-1:0]    w_head;
  logic [IR_W-1:0]  w_head_ir;
  logic [NCH-1:0]   w_head_sel;
  logic             w_full, w_pop, w_push, w_drop;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_ir  = w_head[EW-1:DR_W];
  assign w_head_sel = NCH'(1) << w_head_ir;
  assign w_full     = (r_level == LVL_W'(DEPTH));
  assign w_pop      = (r_level != '0) && bus.cmd_ready;
  // A full queue still accepts a scan when the head leaves in the same cycle.
  assign w_push     = w_udr_p && (!w_full || w_pop);
  assign w_drop     = w_udr_p && !w_push;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.ir_in, bus.sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_jdo        <= '0;
      r_take_act   <= '0;
      r_take_nact  <= '0;
      r_ir_latched <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      if (w_drop)            r_overflow <= 1'b1;
      else if (bus.ovf_clr)  r_overflow <= 1'b0;
      r_take_act  <= '0;
      r_take_nact <= '0;
      if (w_pop) begin
        r_jdo <= w_head[DR_W-1:0];
        if (w_head[ACT_BIT]) r_take_act  <= w_head_sel;
        else                 r_take_nact <= w_head_sel;
      end
      if (w_uir_p) r_ir_latched <= bus.ir_in;
    end
  end

  assign bus.jdo            = r_jdo;
  assign bus.take_action    = r_take_act;
  assign bus.take_no_action = r_take_nact;
  assign bus.ir_update      = w_uir_p;
  assign bus.ir_latched     = r_ir_latched;
  assign bus.fifo_level     = r_level;
  assign bus.overflow       = r_overflow;
endmodule

// File: tb/tb_jtag_debug_sysclk_cmd_queue.sv
// Scoreboard bench for the JTAG debug command queue: expected dispatches are
// queued as scans are driven and checked when the pulses appear.
module tb_jtag_debug_sysclk_cmd_queue;
  localparam int SYNC = 2;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] sr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_disp = 0;
  int   last_disp_cyc = 0;
  int   last_rise_cyc = 0;
  int   disp_cycs[$];
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] mon_a, mon_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  jtag_debug_sysclk_cmd_queue_if #(.IR_W(2), .DR_W(38), .DEPTH(4)) bus ();

  jtag_debug_sysclk_cmd_queue #(
    .IR_W(2), .DR_W(38), .ACT_BIT(35), .DEPTH(4), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Every dispatch pulse is matched against the oldest expected command.
  always @(negedge clk) begin
    if (reset === 1'b0 && ((|bus.take_action) === 1'b1 || (|bus.take_no_action) === 1'b1)) begin
      n_disp++;
      last_disp_cyc = cyc;
      disp_cycs.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_dispatch act=%b nact=%b jdo=%h required no pulse",
                 bus.take_action, bus.take_no_action, bus.jdo);
      end else begin
        mon_e = sb.pop_front();
        mon_a = mon_e.sr[35] ? (4'b0001 << mon_e.ir) : 4'b0000;
        mon_n = mon_e.sr[35] ? 4'b0000 : (4'b0001 << mon_e.ir);
        if (bus.take_action !== mon_a || bus.take_no_action !== mon_n || bus.jdo !== mon_e.sr) begin
          n_err++;
          $display("FAIL dispatch act=%b nact=%b jdo=%h required act=%b nact=%b jdo=%h",
                   bus.take_action, bus.take_no_action, bus.jdo, mon_a, mon_n, mon_e.sr);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, run aborted");
    $fatal(1);
  end

  task automatic scan(input logic [1:0] ir, input logic [37:0] srv,
                      input bit spec, input bit rdy, input bit clr);
    logic saved;
    bus.ir_in = ir;
    bus.sr = srv;
    bus.vs_udr = 1'b1;
    last_rise_cyc = cyc;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    saved = bus.cmd_ready;
    if (spec) begin
      bus.cmd_ready = rdy;
      bus.ovf_clr = clr;
    end
    @(posedge clk);
    #1;
    if (spec) begin
      bus.cmd_ready = saved;
      bus.ovf_clr = 1'b0;
    end
    bus.vs_udr = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1;
  endtask

  task automatic wait_disp(input int target, input string name);
    int k = 0;
    while (n_disp < target && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (n_disp != target) begin
      n_err++;
      $display("FAIL %s dispatch_count got=%0d required=%0d", name, n_disp, target);
    end
  endtask

  task automatic test_reset();
    int pulses = 0;
    reset = 1'b1;
    bus.vs_udr = 1'b1;
    bus.vs_uir = 1'b1;
    bus.ir_in = '0;
    bus.sr = '0;
    bus.cmd_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ((|bus.take_action) !== 1'b0 || (|bus.take_no_action) !== 1'b0 || bus.ir_update !== 1'b0)
        pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL reset_pulses got=%0d required=0", pulses); end
    n_cmp++;
    if (bus.fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got=%0d required=0", bus.fifo_level); end
    n_cmp++;
    if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b required=0", bus.overflow); end
    n_cmp++;
    if (bus.jdo !== 38'd0 || bus.ir_latched !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs jdo=%h ir_latched=%0d required 0/0", bus.jdo, bus.ir_latched);
    end
    @(posedge clk);
    #1;
    bus.vs_udr = 1'b0;
    bus.vs_uir = 1'b0;
    repeat (SYNC + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_single_action();
    int d0 = n_disp;
    bus.cmd_ready = 1'b1;
    sb.push_back('{ir: 2'd2, sr: 38'h08_0000_1234});
    scan(2'd2, 38'h08_0000_1234, 1'b0, 1'b0, 1'b0);
    wait_disp(d0 + 1, "single_action");
    n_cmp++;
    if (last_disp_cyc - last_rise_cyc != SYNC + 3) begin
      n_err++;
      $display("FAIL single_latency got=%0d required=%0d", last_disp_cyc - last_rise_cyc, SYNC + 3);
    end
    n_cmp++;
    if (bus.jdo !== 38'h08_0000_1234) begin
      n_err++;
      $display("FAIL single_jdo_hold got=%h required=%h", bus.jdo, 38'h08_0000_1234);
    end
  endtask

  task automatic test_single_no_action();
    int d0 = n_disp;
    sb.push_back('{ir: 2'd0, sr: 38'h00_0000_0abc});
    scan(2'd0, 38'h00_0000_0abc, 1'b0, 1'b0, 1'b0);
    wait_disp(d0 + 1, "single_no_action");
    n_cmp++;
    if (bus.jdo !== 38'h00_0000_0abc) begin
      n_err++;
      $display("FAIL no_action_jdo_hold got=%h required=%h", bus.jdo, 38'h00_0000_0abc);
    end
  endtask

  task automatic test_fill_overflow();
    int d0;
    bus.cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back('{ir: 2'd1, sr: 38'(i)});
      scan(2'd1, 38'(i), 1'b0, 1'b0, 1'b0);
    end
    n_cmp++;
    if (bus.fifo_level !== 3'd4) begin n_err++; $display("FAIL fill_level got=%0d required=4", bus.fifo_level); end
    n_cmp++;
    if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow got=%b required=1", bus.overflow); end
    disp_cycs.delete();
    d0 = n_disp;
    bus.cmd_ready = 1'b1;
    wait_disp(d0 + 4, "drain");
    n_cmp++;
    if (disp_cycs.size() != 4 || disp_cycs[disp_cycs.size()-1] - disp_cycs[0] != 3) begin
      n_err++;
      $display("FAIL drain_back_to_back got_count=%0d required count=4 span=3", disp_cycs.size());
    end
    n_cmp++;
    if (bus.fifo_level !== 3'd0) begin n_err++; $display("FAIL drain_level got=%0d required=0", bus.fifo_level); end
  endtask

  task automatic test_full_push_pop();
    int d0;
    bus.cmd_ready = 1'b0;
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr_alone got=%b required=0", bus.overflow); end
    for (int i = 10; i <= 13; i++) begin
      sb.push_back('{ir: 2'd3, sr: {2'b00, i[0], 35'(i)}});
      scan(2'd3, {2'b00, i[0], 35'(i)}, 1'b0, 1'b0, 1'b0);
    end
    d0 = n_disp;
    sb.push_back('{ir: 2'd3, sr: 38'd14});
    scan(2'd3, 38'd14, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0 || n_disp != d0 + 1) begin
      n_err++;
      $display("FAIL full_push_pop level=%0d ovf=%b disp=%0d required level=4 ovf=0 disp=1",
               bus.fifo_level, bus.overflow, n_disp - d0);
    end
    scan(2'd3, 38'd15, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.fifo_level !== 3'd4) begin
      n_err++;
      $display("FAIL drop_with_clr ovf=%b level=%0d required ovf=1 level=4", bus.overflow, bus.fifo_level);
    end
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr_again got=%b required=0", bus.overflow); end
    d0 = n_disp;
    bus.cmd_ready = 1'b1;
    wait_disp(d0 + 4, "full_drain");
    n_cmp++;
    if (bus.fifo_level !== 3'd0) begin n_err++; $display("FAIL full_drain_level got=%0d required=0", bus.fifo_level); end
  endtask

  task automatic test_ir_and_reset();
    int ir_pulses = 0;
    int d0;
    bus.cmd_ready = 1'b0;
    bus.ir_in = 2'd3;
    bus.vs_uir = 1'b1;
    repeat (SYNC + 4) begin
      @(negedge clk);
      if (bus.ir_update === 1'b1) ir_pulses++;
    end
    bus.vs_uir = 1'b0;
    n_cmp++;
    if (ir_pulses != 1) begin n_err++; $display("FAIL ir_update_pulses got=%0d required=1", ir_pulses); end
    n_cmp++;
    if (bus.ir_latched !== 2'd3 || bus.fifo_level !== 3'd0) begin
      n_err++;
      $display("FAIL ir_latched got=%0d level=%0d required 3/0", bus.ir_latched, bus.fifo_level);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) scan(2'd2, 38'h08_0000_0100 + 38'(i), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.fifo_level !== 3'd3) begin n_err++; $display("FAIL queued_level got=%0d required=3", bus.fifo_level); end
    d0 = n_disp;
    reset = 1'b1;
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_mid_level got=%0d required=0", bus.fifo_level); end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (n_disp != d0 || bus.fifo_level !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid_discard disp=%0d level=%0d required 0/0", n_disp - d0, bus.fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single_action();
    test_single_no_action();
    test_fill_overflow();
    test_full_push_pop();
    test_ir_and_reset();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d required=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jtag_debug_sysclk_cmd_queue.md
Name: jtag_debug_sysclk_cmd_queue

Overview:
Parametrised system-clock side of the Nios II JTAG debug module.
- Synchronises the update-DR and update-IR strobes from the TCK domain.
- Captures each scanned command (instruction plus shift-register word) into a small FIFO, so back-to-back scans are not lost while the CPU debug logic is busy.
- Dispatches queued commands one at a time under a ready handshake, as one-hot take_action / take_no_action pulses with the matching jdo word.
- Sits between the virtual-JTAG TCK-domain shifter and the OCI break, ocimem, tracectrl and tracemem consumers.

Parameters:
IR_W, 2, instruction width; NCH = 2**IR_W action channels
DR_W, 38, shift-register / jdo width
ACT_BIT, 35, bit of sr selecting action (1) vs no-action (0); must be < DR_W
DEPTH, 4, command FIFO entries; power of two, >= 2
SYNC_STAGES, 2, synchroniser flops per strobe; >= 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ir_in  in  IR_W  TCK-domain instruction; stable while vs_udr is high
sr  in  DR_W  TCK-domain shift register; stable while vs_udr is high
vs_udr  in  1  async update-DR level from TCK domain
vs_uir  in  1  async update-IR level from TCK domain
cmd_ready  in  1  consumer can accept a command this cycle
ovf_clr  in  1  clears overflow
jdo  out  DR_W  data of the last dispatched command
take_action  out  NCH  one-hot 1-cycle pulse, indexed by the command's ir
take_no_action  out  NCH  one-hot 1-cycle pulse, indexed by the command's ir
ir_update  out  1  1-cycle pulse on a synchronised vs_uir rising edge
ir_latched  out  IR_W  ir_in sampled on ir_update
fifo_level  out  $clog2(DEPTH+1)  occupied entries
overflow  out  1  sticky: a command was dropped

Behaviour:
Single clock domain (clk); reset is synchronous and active-high, as already decided.

Reset:
- FIFO is emptied; fifo_level=0, overflow=0.
- jdo=0, take_action=0, take_no_action=0, ir_update=0, ir_latched=0.
- All synchroniser and edge-history flops reset to 1, so a strobe already high at reset release produces no edge.

Synchronisers and edge detect:
- Each strobe passes through SYNC_STAGES flops, then a history flop.
- A rising edge gives udr_p or uir_p for exactly one cycle.
- Latency from strobe level change to pulse: SYNC_STAGES+1 clk cycles.

Push:
- On udr_p, the entry {ir_in, sr} is written at the tail.
- Sampling happens in the udr_p cycle, direct from the ports.
- A push is accepted if not full, or if a pop occurs in the same cycle.
- Otherwise the entry is dropped, overflow is set to 1, and the FIFO is unchanged.

Pop / dispatch:
- Pop condition: fifo_level != 0 && cmd_ready.
- The cycle after a pop, jdo <= entry.sr.
- In that same cycle, take_action[entry.ir]=1 if entry.sr[ACT_BIT], else take_no_action[entry.ir]=1.
- All other pulse bits are 0, and at most one bit across both vectors is high.
- jdo holds its value until the next dispatch.
- No bypass: a push into an empty FIFO is poppable in the following cycle at the earliest.
- Minimum latency from udr_p to the action pulse is therefore 2 cycles.
- Sustained throughput: 1 command per cycle while cmd_ready=1.

Simultaneous events:
- Push and pop in the same cycle: fifo_level is unchanged.
- Full plus push plus pop: both succeed.
- ovf_clr and a drop in the same cycle: set wins, overflow stays 1.

Update-IR path:
- On uir_p: ir_update=1 for that cycle and ir_latched <= ir_in.
- Independent of the FIFO.

Pointers:
- log2(DEPTH) bits wide, wrapping naturally.
- fifo_level is a separate counter, saturating at DEPTH by construction.

Reset mid-operation:
- Queued commands are discarded.
- A pulse scheduled for the next cycle is suppressed.

Decomposition:
- Shared package/include holds:
  - ACT_BIT default;
  - the IR encodings JTAG_IR_OCIMEM=0, JTAG_IR_TRACEMEM=1, JTAG_IR_BREAK=2, JTAG_IR_TRACECTRL=3;
  - a localparam for the entry width IR_W+DR_W.
- One sub-module, jtag_debug_sync_edge (parameter SYNC_STAGES; ports clk, reset, async_in, rise_p), instantiated twice.
- The FIFO stays inline.

Test Plan:
1. Reset with vs_udr=1 held, release, hold 10 cycles -> no pulses; fifo_level=0; overflow=0.
2. Single command: ir_in=2, sr=38'h08_0000_1234 (bit35=1), toggle vs_udr with cmd_ready=1 -> take_action=4'b0100 exactly once, SYNC_STAGES+3 cycles after the vs_udr rise; jdo=38'h08_0000_1234.
3. Same with sr bit35=0, ir_in=0 -> take_no_action=4'b0001, take_action=0.
4. cmd_ready=0, five scans (DEPTH=4) with sr=1..5 -> fifo_level=4, overflow=1; then cmd_ready=1 -> four dispatches in consecutive cycles with jdo=1,2,3,4; sr=5 never dispatched.
5. FIFO full with push and pop in the same cycle -> both accepted, fifo_level stays 4, overflow unchanged. ovf_clr asserted alone clears overflow; asserted together with a drop leaves overflow=1.
6. vs_uir rise with ir_in=3 -> ir_update pulses once, ir_latched=3, fifo_level unchanged. Reset asserted with 3 queued entries -> fifo_level=0 and no further pulses.
